// File: rtl/pio_shift_out_pkg.sv
// Shared types and helpers for the PIO-to-74HC595 serialiser.
package pio_shift_out_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } state_e;

  // Width of a down-counter that must hold n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pio_shift_out.sv
// Serialises the parallel PIO value to a 74HC595-style shift/latch register,
// refreshing after reset and whenever the sampled value changes.
module pio_shift_out
  import pio_shift_out_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] in_port,
  output logic              busy,
  output logic              sr_data,
  output logic              sr_clk,
  output logic              sr_latch,
  output logic              sr_oe_n
);

  localparam int DIV_W = cnt_w(CLK_DIV);
  localparam int BIT_W = cnt_w(DATA_W);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LOAD = BIT_W'(DATA_W - 1);

  state_e             state;
  logic               pending;
  logic [DATA_W-1:0]  in_q;
  logic [DATA_W-1:0]  sent_q;
  logic [DATA_W-1:0]  shreg;
  logic [DATA_W-1:0]  shreg_nxt;
  logic [DIV_W-1:0]   div_cnt;
  logic [BIT_W-1:0]   bit_cnt;

  function automatic logic first_bit(input logic [DATA_W-1:0] v);
    return MSB_FIRST ? v[DATA_W-1] : v[0];
  endfunction

  // NOTE: every signal assigned in always_comb gets a value on all paths, so no latch is inferred.
  always_comb begin
    shreg_nxt = shreg;
    if (MSB_FIRST) shreg_nxt = shreg << 1;
    else           shreg_nxt = shreg >> 1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      pending  <= 1'b1;
      in_q     <= '0;
      sent_q   <= '0;
      shreg    <= '0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      busy     <= 1'b0;
      sr_data  <= 1'b0;
      sr_clk   <= 1'b0;
      sr_latch <= 1'b0;
      sr_oe_n  <= 1'b1;
    end else begin
      in_q <= in_port;
      case (state)
        IDLE: begin
          if (pending || (in_q != sent_q)) begin
            shreg   <= in_q;
            sent_q  <= in_q;
            pending <= 1'b0;
            bit_cnt <= BIT_LOAD;
            div_cnt <= DIV_LOAD;
            sr_data <= first_bit(in_q);
            busy    <= 1'b1;
            state   <= SHIFT_LO;
          end
        end
        SHIFT_LO: begin
          if (div_cnt == '0) begin
            div_cnt <= DIV_LOAD;
            sr_clk  <= 1'b1;
            state   <= SHIFT_HI;
          end else begin
            div_cnt <= div_cnt - DIV_W'(1);
          end
        end
        SHIFT_HI: begin
          if (div_cnt == '0) begin
            div_cnt <= DIV_LOAD;
            sr_clk  <= 1'b0;
            if (bit_cnt == '0) begin
              sr_latch <= 1'b1;
              state    <= LATCH;
            end else begin
              // Data moves only here, while sr_clk drops, keeping it stable around each rise.
              shreg   <= shreg_nxt;
              sr_data <= first_bit(shreg_nxt);
              bit_cnt <= bit_cnt - BIT_W'(1);
              state   <= SHIFT_LO;
            end
          end else begin
            div_cnt <= div_cnt - DIV_W'(1);
          end
        end
        LATCH: begin
          if (div_cnt == '0) begin
            sr_latch <= 1'b0;
            sr_oe_n  <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            div_cnt <= div_cnt - DIV_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pio_shift_out.sv
// Directed and randomised checks of pio_shift_out; frames are decoded from the
// serial pins and compared with values predicted from the port history.
module tb_pio_shift_out;

  localparam int DATA_W = 8;

  typedef struct {
    int val;
    int blen;
    int nbits;
    int llen;
    int viol;
    int per_min;
    int per_max;
    int first;
    int oe_last;
    int seen;
  } frame_t;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [DATA_W-1:0] in_port = '0;
  logic [DATA_W-1:0] in_port2 = '0;
  logic busy, sr_data, sr_clk, sr_latch, sr_oe_n;
  logic busy2, sr_data2, sr_clk2, sr_latch2, sr_oe_n2;
  logic sel = 1'b0;
  logic m_busy, m_data, m_clk, m_latch, m_oe;

  int checks = 0;
  int errors = 0;

  pio_shift_out #(.DATA_W(DATA_W), .CLK_DIV(4), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .in_port(in_port), .busy(busy),
    .sr_data(sr_data), .sr_clk(sr_clk), .sr_latch(sr_latch), .sr_oe_n(sr_oe_n)
  );

  pio_shift_out #(.DATA_W(DATA_W), .CLK_DIV(1), .MSB_FIRST(1'b0)) dut2 (
    .clk(clk), .reset_n(reset_n), .in_port(in_port2), .busy(busy2),
    .sr_data(sr_data2), .sr_clk(sr_clk2), .sr_latch(sr_latch2), .sr_oe_n(sr_oe_n2)
  );

  assign m_busy  = sel ? busy2     : busy;
  assign m_data  = sel ? sr_data2  : sr_data;
  assign m_clk   = sel ? sr_clk2   : sr_clk;
  assign m_latch = sel ? sr_latch2 : sr_latch;
  assign m_oe    = sel ? sr_oe_n2  : sr_oe_n;

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [DATA_W-1:0] v);
    @(posedge clk);
    #1;
    if (sel) in_port2 = v;
    else     in_port  = v;
  endtask

  // Change before edge k: busy still low after k, high after k+1. Ends on a negedge.
  task automatic set_and_check_latency(input string tag, input logic [DATA_W-1:0] v);
    set_in(v);
    @(negedge clk);
    @(negedge clk);
    check({tag, "_lat_lo"}, m_busy, 1'b0);
    @(negedge clk);
    check({tag, "_lat_hi"}, m_busy, 1'b1);
  endtask

  // Decodes one frame from the pins; called on a negedge, returns on the first idle negedge.
  task automatic capture(output frame_t f);
    bit   bits[$];
    int   waited;
    int   last_rise;
    logic pc, pd;
    f = '{default: 0};
    f.per_min = 1000;
    waited = 0;
    last_rise = -1;
    while (!m_busy && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    f.seen = int'(m_busy);
    pc = m_clk;
    pd = m_data;
    while (m_busy && f.blen < 400) begin
      if (m_clk && !pc) begin
        bits.push_back(m_data);
        if (last_rise >= 0) begin
          if (f.blen - last_rise < f.per_min) f.per_min = f.blen - last_rise;
          if (f.blen - last_rise > f.per_max) f.per_max = f.blen - last_rise;
        end
        last_rise = f.blen;
      end
      if (m_clk && pc && (m_data !== pd)) f.viol++;
      if (m_latch) f.llen++;
      f.oe_last = int'(m_oe);
      pc = m_clk;
      pd = m_data;
      f.blen++;
      @(negedge clk);
    end
    f.nbits = bits.size();
    if (f.nbits > 0) f.first = int'(bits[0]);
    foreach (bits[i])
      if (bits[i]) f.val += sel ? (1 << i) : (1 << (f.nbits - 1 - i));
  endtask

  task automatic expect_frame(input string tag, input logic [DATA_W-1:0] exp_val, output frame_t f);
    int div;
    div = sel ? 1 : 4;
    capture(f);
    check({tag, "_seen"}, f.seen, 1);
    check({tag, "_val"}, f.val, exp_val);
    check({tag, "_nbits"}, f.nbits, DATA_W);
    check({tag, "_busy_len"}, f.blen, DATA_W * 2 * div + div);
    check({tag, "_latch_len"}, f.llen, div);
    check({tag, "_data_stable"}, f.viol, 0);
    if (f.nbits > 1) begin
      check({tag, "_per_min"}, f.per_min, 2 * div);
      check({tag, "_per_max"}, f.per_max, 2 * div);
    end
  endtask

  task automatic idle_gap(input int limit, output int gap);
    gap = 0;
    while (!m_busy && gap < limit) begin
      gap++;
      @(negedge clk);
    end
  endtask

  initial begin
    frame_t            f;
    int                gap;
    int                rises;
    int                w;
    int                nchg;
    logic              pc;
    logic [DATA_W-1:0] v;
    logic [DATA_W-1:0] last;
    logic [DATA_W-1:0] sent;
    logic [DATA_W-1:0] vals[5];

    // Reset values and the refresh frame of 0x00.
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_sr_data", sr_data, 1'b0);
    check("rst_sr_clk", sr_clk, 1'b0);
    check("rst_sr_latch", sr_latch, 1'b0);
    check("rst_sr_oe_n", sr_oe_n, 1'b1);
    reset_n = 1'b1;
    @(negedge clk);
    check("t1_busy_after_release", busy, 1'b1);
    expect_frame("t1", 8'h00, f);
    check("t1_oe_during_frame", f.oe_last, 1);
    check("t1_oe_after_latch", sr_oe_n, 1'b0);
    idle_gap(150, gap);
    check("t1_no_more_frames", gap, 150);
    sent = 8'h00;

    // Stable values: one frame each, nothing further.
    vals[0] = 8'hA5;
    for (int i = 1; i < 5; i++) vals[i] = DATA_W'($urandom_range(0, 255));
    for (int i = 0; i < 5; i++) begin
      v = (vals[i] == sent) ? (vals[i] ^ 8'h01) : vals[i];
      set_and_check_latency("t2", v);
      expect_frame("t2", v, f);
      idle_gap(100, gap);
      check("t2_no_more_frames", gap, 100);
      sent = v;
    end

    // Change mid-frame: frame in flight unchanged, one idle cycle, then the new value.
    set_and_check_latency("t3", 8'h3C);
    fork
      expect_frame("t3_first", 8'h3C, f);
      begin
        repeat (20) @(posedge clk);
        #1 in_port = 8'hC3;
      end
    join
    idle_gap(100, gap);
    check("t3_idle_gap", gap, 1);
    expect_frame("t3_second", 8'hC3, f);
    idle_gap(100, gap);
    check("t3_no_more_frames", gap, 100);

    // Intermediate values dropped; returning to the sent value means no new frame.
    set_and_check_latency("t4a", 8'h3C);
    fork
      expect_frame("t4a", 8'h3C, f);
      begin
        repeat (10) @(posedge clk);
        #1 in_port = 8'h11;
        repeat (10) @(posedge clk);
        #1 in_port = 8'h22;
        repeat (10) @(posedge clk);
        #1 in_port = 8'h3C;
      end
    join
    idle_gap(100, gap);
    check("t4a_no_more_frames", gap, 100);

    set_and_check_latency("t4b", 8'h5A);
    fork
      expect_frame("t4b_first", 8'h5A, f);
      begin
        repeat (10) @(posedge clk);
        #1 in_port = 8'h11;
        repeat (10) @(posedge clk);
        #1 in_port = 8'h22;
      end
    join
    idle_gap(100, gap);
    check("t4b_idle_gap", gap, 1);
    expect_frame("t4b_second", 8'h22, f);
    idle_gap(100, gap);
    check("t4b_no_more_frames", gap, 100);
    sent = 8'h22;

    // Random bursts during a frame: only the last value matters, and only if it differs.
    for (int it = 0; it < 4; it++) begin
      v = DATA_W'($urandom_range(0, 255));
      if (v == sent) v = v ^ 8'h80;
      nchg = $urandom_range(1, 3);
      last = v;
      set_and_check_latency("rnd", v);
      fork
        expect_frame("rnd_first", v, f);
        begin
          for (int k = 0; k < nchg; k++) begin
            repeat (12) @(posedge clk);
            last = (k == nchg - 1 && it[0]) ? v : DATA_W'($urandom_range(0, 255));
            #1 in_port = last;
          end
        end
      join
      if (last != v) begin
        idle_gap(100, gap);
        check("rnd_idle_gap", gap, 1);
        expect_frame("rnd_second", last, f);
      end
      idle_gap(100, gap);
      check("rnd_no_more_frames", gap, 100);
      sent = last;
    end

    // One-cycle pulse in IDLE is sent, then the restored value follows.
    v = sent ^ 8'hFF;
    set_in(v);
    set_in(sent);
    @(negedge clk);
    check("pulse_lat_lo", busy, 1'b0);
    @(negedge clk);
    check("pulse_lat_hi", busy, 1'b1);
    expect_frame("pulse", v, f);
    idle_gap(100, gap);
    check("pulse_idle_gap", gap, 1);
    expect_frame("pulse_restore", sent, f);
    idle_gap(100, gap);
    check("pulse_no_more_frames", gap, 100);

    // Reset during bit 3 aborts at once; refresh follows release.
    set_and_check_latency("t5", 8'hF0);
    rises = 0;
    w = 0;
    pc = sr_clk;
    while (rises < 3 && w < 300) begin
      @(negedge clk);
      w++;
      if (sr_clk && !pc) rises++;
      pc = sr_clk;
    end
    check("t5_bit_reached", rises, 3);
    repeat (6) @(negedge clk);
    check("t5_busy_before", busy, 1'b1);
    check("t5_oe_before", sr_oe_n, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_sr_data", sr_data, 1'b0);
    check("t5_rst_sr_clk", sr_clk, 1'b0);
    check("t5_rst_sr_latch", sr_latch, 1'b0);
    check("t5_rst_sr_oe_n", sr_oe_n, 1'b1);
    in_port = 8'h96;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    // The first refresh carries the cleared in_q; the live value follows as a change.
    expect_frame("t5_refresh", 8'h00, f);
    check("t5_oe_during_refresh", f.oe_last, 1);
    idle_gap(100, gap);
    check("t5_idle_gap", gap, 1);
    expect_frame("t5_current", 8'h96, f);
    idle_gap(100, gap);
    check("t5_no_more_frames", gap, 100);

    // LSB-first, CLK_DIV=1 instance.
    sel = 1'b1;
    set_and_check_latency("t6", 8'h01);
    expect_frame("t6", 8'h01, f);
    check("t6_first_bit", f.first, 1);
    idle_gap(60, gap);
    check("t6_no_more_frames", gap, 60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
